// File: rtl/cache_pkg.sv
// Shared line-interface widths, L2 geometry and controller state encoding.
// L1 imports this package as well so both sides agree on line/address shapes.
package cache_pkg;
    localparam int LINES  = 64;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        WB      = 2'd2,
        ALLOC   = 2'd3
    } state_t;

    function automatic idx_t idx_of(input addr_t a);
        return a[IDX_W-1:0];
    endfunction

    function automatic tag_t tag_of(input addr_t a);
        return a[ADDR_W-1:IDX_W];
    endfunction
endpackage

// File: rtl/l2_tag_array.sv
// Valid/dirty/tag storage for the direct-mapped L2 with a combinational
// lookup of the indexed entry against the requested tag.
module l2_tag_array
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  idx_t idx,
    input  tag_t tag,
    input  logic install,
    input  logic install_dirty,
    input  logic set_dirty,
    input  logic clr_dirty,
    output logic hit,
    output logic victim_valid,
    output logic victim_dirty,
    output tag_t victim_tag
);
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    tag_t             tags [LINES];

    // Install takes priority so a write-back followed by a write install
    // in the same cycle leaves the line dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (install) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= install_dirty;
        end else if (set_dirty) begin
            dirty[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tags[idx] <= tag;
        end
    end

    assign victim_valid = valid[idx];
    assign victim_dirty = dirty[idx];
    assign victim_tag   = tags[idx];
    assign hit          = valid[idx] && (tags[idx] == tag);
endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 answering L1 line requests; misses fetch from
// memory over a line handshake, writing dirty victims back first.
module l2_cache
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    // Handshake: read/write are held by L1 until it sees the one-cycle ready
    // pulse; mem_read/mem_write are held until the one-cycle mem_ready pulse.

    state_t state;
    state_t state_next;

    logic  req_write;
    addr_t req_addr;
    line_t req_wdata;
    logic  relookup;

    line_t data_mem [LINES];

    idx_t  idx;
    tag_t  tag;
    logic  hit;
    logic  victim_valid;
    logic  victim_dirty;
    tag_t  victim_tag;
    logic  victim_wb;
    logic  accept;
    logic  hit_write;
    logic  install;
    logic  clr_dirty;
    logic  data_we;
    line_t data_in;

    assign idx       = idx_of(req_addr);
    assign tag       = tag_of(req_addr);
    assign victim_wb = victim_valid && victim_dirty;
    // While ready is high L1 still holds the finished request; don't take it again.
    assign accept    = (state == IDLE) && (read || write) && !ready;
    assign hit_write = (state == COMPARE) && hit && req_write;
    assign install   = ((state == COMPARE) && !hit && !victim_wb && req_write)
                     || ((state == WB) && mem_ready && req_write)
                     || ((state == ALLOC) && mem_ready);
    assign clr_dirty = (state == WB) && mem_ready && !req_write;
    assign data_we   = hit_write || install;
    assign data_in   = (state == ALLOC) ? mem_rdata : req_wdata;

    l2_tag_array u_tags (
        .clk          (clk),
        .rst          (proc_reset),
        .idx          (idx),
        .tag          (tag),
        .install      (install),
        .install_dirty(req_write),
        .set_dirty    (hit_write),
        .clr_dirty    (clr_dirty),
        .hit          (hit),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag)
    );

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[idx] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COMPARE;
            COMPARE: begin
                if (hit)            state_next = IDLE;
                else if (victim_wb) state_next = WB;
                else if (req_write) state_next = IDLE;
                else                state_next = ALLOC;
            end
            WB:      if (mem_ready) state_next = req_write ? IDLE : ALLOC;
            ALLOC:   if (mem_ready) state_next = COMPARE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            rdata     <= '0;
            ready     <= 1'b0;
            stall     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            relookup  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_write <= write;
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        relookup  <= 1'b0;
                    end
                end
                COMPARE: begin
                    // The lookup after a fill is bookkeeping, not a new access.
                    if (!relookup) begin
                        if (hit) hit_cnt  <= hit_cnt + 16'd1;
                        else     miss_cnt <= miss_cnt + 16'd1;
                    end
                    if (hit) begin
                        if (!req_write) rdata <= data_mem[idx];
                        ready <= 1'b1;
                    end else if (victim_wb) begin
                        mem_write <= 1'b1;
                        mem_addr  <= {victim_tag, idx};
                        mem_wdata <= data_mem[idx];
                        stall     <= 1'b1;
                    end else if (req_write) begin
                        ready <= 1'b1;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= req_addr;
                        stall    <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        if (req_write) begin
                            stall <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= req_addr;
                        end
                    end
                end
                ALLOC: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        stall    <= 1'b0;
                        relookup <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Directed plus randomized bench for l2_cache against a line-level cache and
// memory model held in plain arrays.
module tb_l2_cache;
    logic          clk = 1'b0;
    logic          proc_reset;
    logic          read;
    logic          write;
    logic [27:0]   addr;
    logic [127:0]  wdata;
    logic [127:0]  rdata;
    logic          ready;
    logic          stall;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic [15:0]   hit_cnt;
    logic [15:0]   miss_cnt;

    int vectors = 0;
    int miscompares = 0;

    bit           m_valid [64];
    bit           m_dirty [64];
    logic [21:0]  m_tag   [64];
    logic [127:0] m_data  [64];
    int           m_hits;
    int           m_misses;
    logic [127:0] mem_model [logic [27:0]];

    always #5 clk = ~clk;

    l2_cache dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .stall     (stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a};
        if (mem_model.exists(a)) return mem_model[a];
        return {32'hC0DE0000 ^ w, ~w, w, 32'h12345678 + w};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ready"}, ready, 1'b0);
        chk({name, "_stall"}, stall, 1'b0);
        chk({name, "_mem_read"}, mem_read, 1'b0);
        chk({name, "_mem_write"}, mem_write, 1'b0);
        chk({name, "_hit_cnt"}, hit_cnt, m_hits[15:0]);
        chk({name, "_miss_cnt"}, miss_cnt, m_misses[15:0]);
    endtask

    // Hold the memory request for lat cycles, then pulse mem_ready.
    task automatic serve(input bit is_wr, input int lat, input logic [127:0] rd);
        logic [27:0] a0;
        a0 = mem_addr;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("hold_req", is_wr ? mem_write : mem_read, 1'b1);
            chk("hold_addr", mem_addr, a0);
            chk("hold_stall", stall, 1'b1);
            chk("hold_ready", ready, 1'b0);
        end
        mem_rdata = rd;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        chk("mem_req_drop", is_wr ? mem_write : mem_read, 1'b0);
    endtask

    task automatic do_req(input bit wr, input logic [27:0] a, input logic [127:0] d, input int lat);
        int           i;
        bit           hit, exp_wb, exp_fill, saw_wb, saw_fill, got;
        logic [27:0]  wb_addr;
        logic [127:0] wb_data, fill_data, exp_rdata;
        int           cyc;
        i         = int'(a[5:0]);
        hit       = m_valid[i] && (m_tag[i] == a[27:6]);
        exp_wb    = !hit && m_valid[i] && m_dirty[i];
        wb_addr   = {m_tag[i], a[5:0]};
        wb_data   = m_data[i];
        exp_fill  = !hit && !wr;
        fill_data = mem_get(a);
        if (hit) m_hits++; else m_misses++;
        if (exp_wb) mem_model[wb_addr] = wb_data;
        if (wr) begin
            m_data[i] = d; m_dirty[i] = 1'b1; m_valid[i] = 1'b1; m_tag[i] = a[27:6];
        end else if (exp_fill) begin
            m_data[i] = fill_data; m_dirty[i] = 1'b0; m_valid[i] = 1'b1; m_tag[i] = a[27:6];
        end
        exp_rdata = m_data[i];

        @(negedge clk);
        read = !wr; write = wr; addr = a; wdata = d;
        saw_wb = 0; saw_fill = 0; got = 0; cyc = 0;
        while (!got && cyc < 400) begin
            if (ready) begin
                got = 1;
                chk("ready_stall_low", stall, 1'b0);
                if (!wr) chk("rdata", rdata, exp_rdata);
                chk("wb_seen", saw_wb, exp_wb);
                chk("fill_seen", saw_fill, exp_fill);
                if (hit) chk("hit_latency", cyc, 2);
            end else if (mem_write) begin
                chk("wb_expected", exp_wb && !saw_wb, 1'b1);
                chk("wb_addr", mem_addr, wb_addr);
                chk("wb_data", mem_wdata, wb_data);
                chk("wb_stall", stall, 1'b1);
                saw_wb = 1;
                serve(1'b1, lat, '0);
                cyc += lat + 1;
            end else if (mem_read) begin
                chk("fill_expected", exp_fill && !saw_fill && (saw_wb == exp_wb), 1'b1);
                chk("fill_addr", mem_addr, a);
                chk("fill_stall", stall, 1'b1);
                saw_fill = 1;
                serve(1'b0, lat, fill_data);
                cyc += lat + 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("ready_seen", got, 1'b1);
        read = 1'b0; write = 1'b0;
        @(negedge clk);
        chk("ready_pulse", ready, 1'b0);
        chk("hit_cnt", hit_cnt, m_hits[15:0]);
        chk("miss_cnt", miss_cnt, m_misses[15:0]);
    endtask

    initial begin
        bit seen;
        proc_reset = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        model_reset();
        mem_model[28'h0000041] = {4{32'hAAAAAAAA}};
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk_idle_outputs("rst");
        proc_reset = 1'b0;

        // cold read miss, then repeat hit
        do_req(1'b0, 28'h0000041, '0, 3);
        chk("t1_rdata_a", m_data[1], {4{32'hAAAAAAAA}});
        do_req(1'b0, 28'h0000041, '0, 0);
        // write hit, then conflicting read forces write-back and fill
        do_req(1'b1, 28'h0000041, {4{32'hBBBBBBBB}}, 1);
        do_req(1'b0, 28'h0000081, '0, 2);
        // clean write miss installs without memory; later conflict writes it back
        do_req(1'b1, 28'h0000002, {4{32'h13572468}}, 1);
        do_req(1'b0, 28'h0000042, '0, 1);

        // reset while a fill is pending
        @(negedge clk);
        read = 1'b1; addr = 28'h00000C1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("t5_mem_read_seen", seen, 1'b1);
        proc_reset = 1'b1;
        #1;
        model_reset();
        chk("t5_rdata", rdata, '0);
        chk("t5_mem_addr", mem_addr, '0);
        chk("t5_mem_wdata", mem_wdata, '0);
        chk_idle_outputs("t5");
        read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        do_req(1'b0, 28'h0000041, '0, 2);

        // long memory latency, then a spurious mem_ready while idle
        do_req(1'b0, 28'h0000105, '0, 20);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        chk_idle_outputs("spurious");
        do_req(1'b0, 28'h0000105, '0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [27:0] ra;
            ra = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            do_req(1'($urandom_range(0, 1)), ra, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
